exec_sequencer: RTL and testbench

EXEC_SEQUENCER -- requirements
Module: exec_sequencer

---
 rtl/seq_pkg.sv | 29 ++
 rtl/exec_sequencer_if.sv | 12 +
 rtl/seq_status_reg.sv | 19 +
 rtl/exec_sequencer.sv | 120 ++++++++++++
 tb/tb_exec_sequencer.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the instruction sequencer: FSM states,
// instruction field widths, the HALT opcode and the flag bit layout.
package seq_pkg;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_e;

  localparam int INSTR_W = 15;
  localparam int OP_W    = 7;
  localparam int LIT_W   = 8;
  localparam int FLAG_W  = 4;

  localparam logic [OP_W-1:0] OP_HALT = 7'h7F;
  localparam int ALU_CLASS_BIT = 6;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // ALU-class instructions are the ones with the class bit clear.
  function automatic logic is_alu_op(input logic [OP_W-1:0] op);
    return ~op[ALU_CLASS_BIT];
  endfunction
endpackage

// File: rtl/exec_sequencer_if.sv
// Instruction-memory fetch handshake between the sequencer (master) and
// the instruction memory (slave).
interface exec_sequencer_if;
   import seq_pkg::*;

   logic               imem_req;
   logic               imem_valid;
   logic [INSTR_W-1:0] imem_data;

   modport master (output imem_req, input imem_valid, input imem_data);
   modport slave  (input imem_req, output imem_valid, output imem_data);
endinterface

// File: rtl/seq_status_reg.sv
// Registered {Z,N,C,V} status flags with a write-enable; holds otherwise.
module seq_status_reg
   import seq_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we_i,
   input  logic [FLAG_W-1:0] flags_i,
   output logic [FLAG_W-1:0] flags_o
);
   logic [FLAG_W-1:0] flags_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    flags_q <= '0;
      else if (we_i) flags_q <= flags_i;
   end

   assign flags_o = flags_q;
endmodule

// File: rtl/exec_sequencer.sv
// Fetch/decode/execute sequencer: drives the instruction fetch handshake,
// latches the instruction, strobes execution and tracks pc and retire count.
module exec_sequencer
   import seq_pkg::*;
#(
   parameter int PC_W  = 8,
   parameter int CNT_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               run,
   input  logic               step,
   input  logic               halt_req,
   exec_sequencer_if.master   imem,
   input  logic               l_pc,
   input  logic [FLAG_W-1:0]  alu_flags,
   output logic [PC_W-1:0]    pc,
   output logic [OP_W-1:0]    opcode,
   output logic [LIT_W-1:0]   literal,
   output logic [FLAG_W-1:0]  status_flags,
   output logic               exec_en,
   output logic               busy,
   output logic               halted,
   output logic [CNT_W-1:0]   instr_count
);
   state_e             state_q, state_d;
   logic               step_mode_q, step_mode_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic [OP_W-1:0]    opcode_q, opcode_d;
   logic [LIT_W-1:0]   literal_q, literal_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               flags_we;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         step_mode_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         step_mode_q <= step_mode_d;
      end
   end

   // Step pulses outside IDLE never reach here, so they cannot queue up.
   always_comb begin
      state_d     = state_q;
      step_mode_d = step_mode_q;
      unique case (state_q)
         S_IDLE: begin
            if (run) begin
               state_d     = S_FETCH;
               step_mode_d = 1'b0;
            end else if (step) begin
               state_d     = S_FETCH;
               step_mode_d = 1'b1;
            end
         end
         S_FETCH:  if (imem.imem_valid) state_d = S_DECODE;
         S_DECODE: state_d = S_EXEC;
         S_EXEC: begin
            if (halt_req || opcode_q == OP_HALT) state_d = S_HALT;
            else if (step_mode_q || !run)         state_d = S_IDLE;
            else                                  state_d = S_FETCH;
         end
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      imem.imem_req = (state_q == S_FETCH);
      exec_en       = (state_q == S_EXEC);
      busy          = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXEC);
      halted        = (state_q == S_HALT);
   end

   always_comb begin
      pc_d      = pc_q;
      opcode_d  = opcode_q;
      literal_d = literal_q;
      cnt_d     = cnt_q;
      if (state_q == S_FETCH && imem.imem_valid) begin
         opcode_d  = imem.imem_data[INSTR_W-1:LIT_W];
         literal_d = imem.imem_data[LIT_W-1:0];
      end
      if (state_q == S_EXEC) begin
         pc_d  = l_pc ? PC_W'(literal_q) : pc_q + 1'b1;
         cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q      <= '0;
         opcode_q  <= '0;
         literal_q <= '0;
         cnt_q     <= '0;
      end else begin
         pc_q      <= pc_d;
         opcode_q  <= opcode_d;
         literal_q <= literal_d;
         cnt_q     <= cnt_d;
      end
   end

   assign flags_we = (state_q == S_EXEC) && is_alu_op(opcode_q);

   seq_status_reg u_status (
      .clk     (clk),
      .rst_n   (rst_n),
      .we_i    (flags_we),
      .flags_i (alu_flags),
      .flags_o (status_flags)
   );

   assign pc          = pc_q;
   assign opcode      = opcode_q;
   assign literal     = literal_q;
   assign instr_count = cnt_q;
endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer; a second instance with a 2-bit counter
// runs in lock-step so counter saturation is reached in a few instructions.
module tb_exec_sequencer;
  import seq_pkg::*;

  logic clk, rst_n, run, step, halt_req, l_pc;
  logic [3:0] alu_flags;
  logic [7:0] pc, literal, pc2, literal2;
  logic [6:0] opcode, opcode2;
  logic [3:0] status_flags, status2;
  logic exec_en, busy, halted, exec_en2, busy2, halted2;
  logic [15:0] instr_count;
  logic [1:0] cnt2;
  int n_chk = 0;
  int n_fail = 0;

  exec_sequencer_if ifc ();
  exec_sequencer_if ifc2 ();
  assign ifc2.imem_valid = ifc.imem_valid;
  assign ifc2.imem_data  = ifc.imem_data;

  exec_sequencer #(.PC_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step), .halt_req(halt_req),
    .imem(ifc.master), .l_pc(l_pc), .alu_flags(alu_flags), .pc(pc),
    .opcode(opcode), .literal(literal), .status_flags(status_flags),
    .exec_en(exec_en), .busy(busy), .halted(halted), .instr_count(instr_count));

  exec_sequencer #(.PC_W(8), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step), .halt_req(halt_req),
    .imem(ifc2.master), .l_pc(l_pc), .alu_flags(alu_flags), .pc(pc2),
    .opcode(opcode2), .literal(literal2), .status_flags(status2),
    .exec_en(exec_en2), .busy(busy2), .halted(halted2), .instr_count(cnt2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One step-mode instruction with imem_valid on the first FETCH cycle.
  task automatic exec_one(input logic [14:0] w, input logic lpc, input logic [3:0] fl);
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("one_fetch_req", ifc.imem_req, 1);
    ifc.imem_valid = 1'b1;
    ifc.imem_data  = w;
    tick();
    ifc.imem_valid = 1'b0;
    l_pc = lpc;
    alu_flags = fl;
    chk("one_decode_en", exec_en, 0);
    tick();
    chk("one_exec_en", exec_en, 1);
    tick();
    l_pc = 1'b0;
    chk("one_after_en", exec_en, 0);
    chk("one_after_busy", busy, 0);
  endtask

  initial begin
    int reqc;
    rst_n = 1'b0; run = 1'b0; step = 1'b0; halt_req = 1'b0; l_pc = 1'b0;
    alu_flags = 4'b0000; ifc.imem_valid = 1'b0; ifc.imem_data = '0;
    #12;
    chk("rst_pc", pc, 0);
    chk("rst_opcode", opcode, 0);
    chk("rst_literal", literal, 0);
    chk("rst_flags", status_flags, 0);
    chk("rst_count", instr_count, 0);
    chk("rst_req", ifc.imem_req, 0);
    chk("rst_exec_en", exec_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    tick();
    rst_n = 1'b1;

    // Continuous mode, imem_valid one cycle after the request.
    run = 1'b1; alu_flags = 4'b1000;
    tick();
    chk("t1_req0", ifc.imem_req, 1);
    tick();
    chk("t1_req1", ifc.imem_req, 1);
    ifc.imem_valid = 1'b1; ifc.imem_data = 15'h0005;
    tick();
    ifc.imem_valid = 1'b0;
    chk("t1_decode_en", exec_en, 0);
    chk("t1_decode_req", ifc.imem_req, 0);
    chk("t1_literal", literal, 8'h05);
    tick();
    chk("t1_exec_en", exec_en, 1);
    run = 1'b0;
    tick();
    chk("t1_en_drop", exec_en, 0);
    chk("t1_pc", pc, 1);
    chk("t1_flags", status_flags, 4'b1000);
    chk("t1_count", instr_count, 1);
    chk("t1_idle", busy, 0);

    // Jump: non-ALU opcode leaves the flags alone.
    exec_one({7'h40, 8'h20}, 1'b1, 4'b0110);
    chk("jmp_pc", pc, 8'h20);
    chk("jmp_flags", status_flags, 4'b1000);
    chk("jmp_count", instr_count, 2);

    // Jump to FF, then sequential increment wraps to 0.
    exec_one({7'h40, 8'hFF}, 1'b1, 4'b0110);
    chk("ff_pc", pc, 8'hFF);
    chk("sat_cnt3", cnt2, 2'd3);
    exec_one({7'h01, 8'h10}, 1'b0, 4'b0101);
    chk("wrap_pc", pc, 8'h00);
    chk("wrap_flags", status_flags, 4'b0101);
    chk("wrap_count", instr_count, 4);
    chk("sat_hold", cnt2, 2'd3);

    // Step with imem_valid delayed five cycles; step during EXEC ignored.
    step = 1'b1;
    tick();
    step = 1'b0;
    reqc = 0;
    for (int i = 0; i < 6; i++) begin
      if (ifc.imem_req) reqc++;
      ifc.imem_valid = (i == 5);
      ifc.imem_data  = {7'h02, 8'h33};
      if (i == 2) chk("opcode_hold", opcode, 7'h01);
      tick();
    end
    ifc.imem_valid = 1'b0;
    alu_flags = 4'b0010;
    chk("step_req_cycles", reqc, 6);
    chk("step_decode_req", ifc.imem_req, 0);
    tick();
    chk("step_exec_en", exec_en, 1);
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("step_idle", busy, 0);
    tick();
    chk("step_ignored_req", ifc.imem_req, 0);
    chk("step_ignored_busy", busy, 0);
    chk("step_pc", pc, 1);
    chk("step_flags", status_flags, 4'b0010);
    chk("step_count", instr_count, 5);

    // Back-to-back in run mode, then halt_req raised during FETCH.
    run = 1'b1; alu_flags = 4'b0001;
    tick();
    ifc.imem_valid = 1'b1; ifc.imem_data = {7'h03, 8'h00};
    tick();
    ifc.imem_valid = 1'b0;
    tick();
    chk("run_exec_en", exec_en, 1);
    tick();
    chk("run_refetch", ifc.imem_req, 1);
    chk("run_pc", pc, 2);
    chk("run_flags", status_flags, 4'b0001);
    halt_req = 1'b1; alu_flags = 4'b0011;
    ifc.imem_valid = 1'b1; ifc.imem_data = {7'h04, 8'h00};
    tick();
    ifc.imem_valid = 1'b0;
    chk("halt_decode_halted", halted, 0);
    tick();
    chk("halt_exec_en", exec_en, 1);
    tick();
    chk("halt_halted", halted, 1);
    chk("halt_busy", busy, 0);
    chk("halt_count", instr_count, 7);
    chk("halt_flags", status_flags, 4'b0011);
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    tick();
    chk("halt_sticky", halted, 1);
    chk("halt_no_req", ifc.imem_req, 0);
    chk("halt_no_count", instr_count, 7);

    // Reset leaves HALT; then HALT opcode halts on its own.
    rst_n = 1'b0;
    #1;
    chk("rst2_halted", halted, 0);
    chk("rst2_count", instr_count, 0);
    run = 1'b0; halt_req = 1'b0;
    tick();
    rst_n = 1'b1;
    exec_one({7'h7F, 8'h00}, 1'b0, 4'b1111);
    chk("hop_halted", halted, 1);
    chk("hop_flags", status_flags, 4'b0000);
    chk("hop_pc", pc, 1);

    // Reset mid-FETCH drops the request at once; late valid is ignored.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("mid_req_before", ifc.imem_req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_req_async", ifc.imem_req, 0);
    chk("mid_busy", busy, 0);
    chk("mid_pc", pc, 0);
    chk("mid_opcode", opcode, 0);
    ifc.imem_valid = 1'b1; ifc.imem_data = {7'h05, 8'h55};
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    ifc.imem_valid = 1'b0;
    chk("mid_valid_ign_op", opcode, 0);
    chk("mid_valid_ign_lit", literal, 0);
    chk("mid_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
